// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - PS/2 host transmitter request/status and pad bundle.
// slave = transmitter side, master = requester/pad side.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  logic       ps2_clk;
  logic       ps2_data;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;

  modport slave (
    input  tx_data, tx_valid, ps2_clk, ps2_data,
    output tx_ready, tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe
  );

  modport master (
    output tx_data, tx_valid, ps2_clk, ps2_data,
    input  tx_ready, tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter (open-drain pad enables).
// Optional PS2_TX_RETRY_EN: NACK/timeout restarts from INHIBIT, up to 2 retries.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic         clk,
  input  logic         rst,
  ps2_host_tx_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       IDX_STOP = 4'd9;

  state_t           state;
  state_t           next_state;
  logic [2:0]       clk_sync;
  logic [1:0]       data_sync;
  logic             ready_en;
  logic [7:0]       byte_q;
  logic             parity_q;
  logic [3:0]       idx;
  logic             data_oe_q;
  logic             nack_q;
  logic [INH_W-1:0] inh_cnt;
  logic [WD_W-1:0]  wdog;
  logic [9:0]       frame;

  logic fall;
  logic bus_idle;
  logic ready;
  logic accept;
  logic counting;
  logic timeout;
  logic finish_ok;
  logic can_retry;
  logic end_txn;

  assign fall      = clk_sync[2] & ~clk_sync[1];
  assign bus_idle  = clk_sync[1] & data_sync[1];
  assign ready     = (state == S_IDLE) && ready_en;
  assign accept    = bus.tx_valid && ready;
  assign frame     = {1'b1, parity_q, byte_q};
  assign counting  = (state == S_SEND) || (state == S_ACK) || (state == S_WAIT_IDLE);
  assign timeout   = counting && (wdog == WD_LAST);
  assign finish_ok = (state == S_WAIT_IDLE) && bus_idle && !timeout;
  assign end_txn   = (timeout || finish_ok) && !can_retry;

`ifdef PS2_TX_RETRY_EN
  logic [1:0] retry_cnt;
  logic       failed;

  assign failed    = timeout || (finish_ok && nack_q);
  assign can_retry = failed && (retry_cnt != 2'd2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retry_cnt <= 2'd0;
    end else if (accept) begin
      retry_cnt <= 2'd0;
    end else if (can_retry) begin
      retry_cnt <= retry_cnt + 2'd1;
    end
  end
`else
  assign can_retry = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
      ready_en  <= 1'b0;
      byte_q    <= 8'h00;
      parity_q  <= 1'b0;
      idx       <= 4'd0;
      data_oe_q <= 1'b0;
      nack_q    <= 1'b0;
      inh_cnt   <= '0;
      wdog      <= '0;
    end else begin
      clk_sync  <= {clk_sync[1:0], bus.ps2_clk};
      data_sync <= {data_sync[0], bus.ps2_data};
      ready_en  <= 1'b1;

      if (accept) begin
        byte_q   <= bus.tx_data;
        parity_q <= ~^bus.tx_data;
      end

      if (state != S_INHIBIT) begin
        inh_cnt <= '0;
      end else if (inh_cnt != INH_LAST) begin
        inh_cnt <= inh_cnt + 1'b1;
      end

      // Start bit stays driven until the device's first falling edge.
      if (state == S_REQ) begin
        idx       <= 4'd0;
        data_oe_q <= 1'b1;
      end else if (state == S_SEND && fall) begin
        data_oe_q <= ~frame[idx];
        if (idx != IDX_STOP) begin
          idx <= idx + 1'b1;
        end
      end

      if (state == S_ACK && fall) begin
        nack_q <= data_sync[1];
      end

      if (state == S_REQ || fall) begin
        wdog <= '0;
      end else if (counting && wdog != WD_LAST) begin
        wdog <= wdog + 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (accept) next_state = S_INHIBIT;
      S_INHIBIT:   if (inh_cnt == INH_LAST) next_state = S_REQ;
      S_REQ:       next_state = S_SEND;
      S_SEND:      if (fall && idx == IDX_STOP) next_state = S_ACK;
      S_ACK:       if (fall) next_state = S_WAIT_IDLE;
      S_WAIT_IDLE: next_state = S_WAIT_IDLE;
      default:     next_state = S_IDLE;
    endcase
    if (timeout || finish_ok) begin
      next_state = can_retry ? S_INHIBIT : S_IDLE;
    end
  end

  always_comb begin
    bus.ps2_clk_oe  = 1'b0;
    bus.ps2_data_oe = 1'b0;
    bus.tx_ready    = ready;
    bus.tx_busy     = (state != S_IDLE);
    bus.tx_done     = end_txn;
    bus.tx_error    = end_txn && (timeout || nack_q);
    case (state)
      S_INHIBIT: bus.ps2_clk_oe = 1'b1;
      S_REQ: begin
        bus.ps2_clk_oe  = 1'b1;
        bus.ps2_data_oe = 1'b1;
      end
      S_SEND:    bus.ps2_data_oe = data_oe_q;
      default: begin
        bus.ps2_clk_oe  = 1'b0;
        bus.ps2_data_oe = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench for ps2_host_tx with a simple PS/2 device model.
module tb_ps2_host_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int done_err_cnt = 0;
  int lone_err_cnt = 0;
  int clk_oe_cnt = 0;

  ps2_host_tx_if bus ();

  assign bus.ps2_clk  = dev_clk & ~bus.ps2_clk_oe;
  assign bus.ps2_data = dev_data & ~bus.ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(2000)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.tx_done) done_cnt++;
    if (bus.tx_done && bus.tx_error) done_err_cnt++;
    if (bus.tx_error && !bus.tx_done) lone_err_cnt++;
    if (bus.ps2_clk_oe) clk_oe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_release();
    int n;
    n = 0;
    while (!bus.ps2_clk_oe && n < 200) begin @(negedge clk); n++; end
    n = 0;
    while (bus.ps2_clk_oe && n < 200) begin @(negedge clk); n++; end
  endtask

  // bits[0] = start, bits[8:1] = d7..d0, bits[9] = parity, bits[10] = stop
  task automatic device_frame(input logic ack, output logic [10:0] bits);
    bits = '0;
    wait_release();
    bits[0] = bus.ps2_data;
    repeat (20) @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      dev_clk = 1'b0;
      repeat (50) @(negedge clk);
      dev_clk = 1'b1;
      bits[i] = bus.ps2_data;
      repeat (50) @(negedge clk);
    end
    dev_data = ack ? 1'b0 : 1'b1;
    repeat (5) @(negedge clk);
    dev_clk = 1'b0;
    repeat (50) @(negedge clk);
    dev_clk = 1'b1;
    repeat (5) @(negedge clk);
    dev_data = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    logic [10:0] bits;
    int d0, e0, l0, c0, n;

    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.tx_ready, 1'b0);
    chk("rst_clk_oe", bus.ps2_clk_oe, 1'b0);
    chk("rst_data_oe", bus.ps2_data_oe, 1'b0);
    chk("rst_busy", bus.tx_busy, 1'b0);
    chk("rst_done", bus.tx_done, 1'b0);
    rst = 1'b1;
    #1 chk("ready_before_clk", bus.tx_ready, 1'b0);
    @(negedge clk);
    chk("ready_after_clk", bus.tx_ready, 1'b1);

    // 8'hED with ACK; later tx_data/tx_valid activity must be ignored
    d0 = done_cnt; e0 = done_err_cnt;
    send_byte(8'hED);
    chk("ed_busy", bus.tx_busy, 1'b1);
    chk("ed_ready_low", bus.tx_ready, 1'b0);
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    device_frame(1'b1, bits);
    repeat (10) @(negedge clk);
    chk("ed_bits", bits, 11'b11111011010);
    chk("ed_done", done_cnt - d0, 1);
    chk("ed_error", done_err_cnt - e0, 0);
    chk("ed_idle_ready", bus.tx_ready, 1'b1);

    // 8'h07: even parity bit, inhibit length
    d0 = done_cnt; e0 = done_err_cnt; c0 = clk_oe_cnt;
    send_byte(8'h07);
    device_frame(1'b1, bits);
    repeat (10) @(negedge clk);
    chk("h07_bits", bits, 11'b10000001110);
    chk("h07_parity", bits[9], 1'b0);
    chk("h07_clk_oe_cycles", clk_oe_cnt - c0, 21);
    chk("h07_done", done_cnt - d0, 1);
    chk("h07_error", done_err_cnt - e0, 0);

    // NACK
    d0 = done_cnt; e0 = done_err_cnt; l0 = lone_err_cnt; c0 = clk_oe_cnt;
    send_byte(8'h55);
`ifdef PS2_TX_RETRY_EN
    device_frame(1'b0, bits);
    chk("nack_no_done_yet", done_cnt - d0, 0);
    chk("retry_busy", bus.tx_busy, 1'b1);
    device_frame(1'b1, bits);
    repeat (10) @(negedge clk);
    chk("retry_bits", bits, 11'b11010101010);
    chk("retry_clk_oe_cycles", clk_oe_cnt - c0, 42);
    chk("retry_done", done_cnt - d0, 1);
    chk("retry_error", done_err_cnt - e0, 0);
`else
    device_frame(1'b0, bits);
    repeat (10) @(negedge clk);
    chk("nack_bits", bits, 11'b11010101010);
    chk("nack_done", done_cnt - d0, 1);
    chk("nack_done_with_error", done_err_cnt - e0, 1);
    chk("nack_error_alone", lone_err_cnt - l0, 0);
`endif

    // device never clocks: watchdog abort
    send_byte(8'h12);
    n = 0;
    while (!(bus.ps2_clk_oe && bus.ps2_data_oe) && n < 100) begin @(negedge clk); n++; end
    chk("to_req_seen", bus.ps2_clk_oe && bus.ps2_data_oe, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.tx_done && n < 8000);
`ifndef PS2_TX_RETRY_EN
    chk("to_cycles", n, 2000);
`endif
    chk("to_done", bus.tx_done, 1'b1);
    chk("to_error", bus.tx_error, 1'b1);
    @(negedge clk);
    chk("to_clk_oe", bus.ps2_clk_oe, 1'b0);
    chk("to_data_oe", bus.ps2_data_oe, 1'b0);
    chk("to_ready", bus.tx_ready, 1'b1);

    // reset after the 4th falling edge
    d0 = done_cnt;
    send_byte(8'hA5);
    wait_release();
    repeat (20) @(negedge clk);
    for (int i = 1; i <= 3; i++) begin
      dev_clk = 1'b0;
      repeat (50) @(negedge clk);
      dev_clk = 1'b1;
      repeat (50) @(negedge clk);
    end
    dev_clk = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_data_oe", bus.ps2_data_oe, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("arst_clk_oe", bus.ps2_clk_oe, 1'b0);
    chk("arst_data_oe", bus.ps2_data_oe, 1'b0);
    chk("arst_busy", bus.tx_busy, 1'b0);
    chk("arst_ready", bus.tx_ready, 1'b0);
    dev_clk = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("arst_ready_back", bus.tx_ready, 1'b1);
    chk("arst_no_done", done_cnt - d0, 0);

    // fresh byte after reset
    d0 = done_cnt; e0 = done_err_cnt;
    send_byte(8'hF4);
    device_frame(1'b1, bits);
    repeat (10) @(negedge clk);
    chk("f4_bits", bits, 11'b10111101000);
    chk("f4_done", done_cnt - d0, 1);
    chk("f4_error", done_err_cnt - e0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
